// File: rtl/shield_monitor.sv
// shield_monitor: drives the LFSR LSB onto an active shield and checks the loopback.
// Define SHIELD_ALARM_STICKY_EN to make the tamper alarm terminal until reset.
module shield_monitor #(
    parameter int NUM_BITS = 16,
    parameter int DELAY    = 2,
    parameter int THRESH_W = 4
) (
    input  logic                i_Clk,
    input  logic                i_rst_n,
    input  logic                i_Enable,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    output logic                o_LFSR_Enable,
    output logic                o_shield_out,
    input  logic                i_shield_in,
    input  logic [THRESH_W-1:0] i_Threshold,
    input  logic                master_key_ready,
    output logic [THRESH_W-1:0] o_mismatch_cnt,
    output logic                o_armed,
    output logic                o_alarm
);

    localparam int WW = (DELAY > 1) ? $clog2(DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        MONITOR,
        ALARM
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DELAY-1:0]    exp_q;
    logic [DELAY-1:0]    exp_shift;
    logic [WW-1:0]       warm_q;
    logic [WW-1:0]       warm_d;
    logic [THRESH_W-1:0] cnt_q;
    logic [THRESH_W-1:0] cnt_d;
    logic [THRESH_W-1:0] cnt_step;
    logic [THRESH_W-1:0] thr_eff;
    logic                alarm_q;
    logic                alarm_d;
    logic                shield_q;
    logic                flush;
    logic                lfsr_en;
    logic                armed;
    logic                lfsr_bit;
    logic                mismatch;
    logic                unused;

    assign lfsr_bit = i_LFSR_Data[0];
    assign unused   = ^{i_LFSR_Data, master_key_ready};

    generate
        if (DELAY == 1) begin : g_d1
            assign exp_shift = lfsr_bit;
        end else begin : g_dn
            assign exp_shift = {exp_q[DELAY-2:0], lfsr_bit};
        end
    endgenerate

    // The oldest tap holds the bit sent DELAY enabled edges ago.
    assign mismatch = i_shield_in != exp_q[DELAY-1];

    assign thr_eff = (i_Threshold == '0) ? THRESH_W'(1) : i_Threshold;

    always_comb begin
        cnt_step = '0;
        if (mismatch) begin
            if (cnt_q == {THRESH_W{1'b1}}) begin
                cnt_step = cnt_q;
            end else begin
                cnt_step = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        warm_d  = warm_q;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_Enable) begin
                    state_d = WARMUP;
                    warm_d  = '0;
                end
            end
            WARMUP: begin
                cnt_d = '0;
                if (!i_Enable) begin
                    state_d = IDLE;
                end else if (warm_q == WW'(DELAY - 1)) begin
                    state_d = MONITOR;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            MONITOR: begin
                if (!i_Enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_step;
                    if (cnt_step >= thr_eff) begin
                        alarm_d = 1'b1;
                        state_d = ALARM;
                    end
                end
            end
            ALARM: begin
`ifndef SHIELD_ALARM_STICKY_EN
                if (master_key_ready) begin
                    alarm_d = 1'b0;
                    cnt_d   = '0;
                    flush   = 1'b1;
                    warm_d  = '0;
                    state_d = i_Enable ? WARMUP : IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        lfsr_en = 1'b0;
        armed   = 1'b0;
        unique case (state_q)
            IDLE: begin
                lfsr_en = 1'b0;
            end
            WARMUP: begin
                lfsr_en = 1'b1;
            end
            MONITOR: begin
                lfsr_en = 1'b1;
                armed   = 1'b1;
            end
            ALARM: begin
                lfsr_en = 1'b1;
            end
            default: begin
                lfsr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shield_q <= 1'b0;
            exp_q    <= '0;
            warm_q   <= '0;
            cnt_q    <= '0;
            alarm_q  <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            if (lfsr_en) begin
                shield_q <= lfsr_bit;
                exp_q    <= flush ? '0 : exp_shift;
            end
        end
    end

    assign o_LFSR_Enable  = lfsr_en;
    assign o_armed        = armed;
    assign o_alarm        = alarm_q;
    assign o_mismatch_cnt = cnt_q;
    assign o_shield_out   = shield_q;

endmodule
